// File: rtl/wb_slave_decoder.sv
// Wishbone slave-side address decoder/router: locks the slave select per bus cycle,
// flags unmapped selects, and (with WB_DEC_TIMEOUT_EN defined) errors out slaves that never ack.
module wb_slave_decoder #(
  parameter int WORD    = 16,
  parameter int SLAVES  = 4,
  parameter int SEL_W   = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  parameter int SEL_H   = WORD - 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [WORD-1:0]   adr_i,
  input  logic [SLAVES-1:0] slvAck_i,
  input  logic [WORD-1:0]   slvDat_i [SLAVES],
  output logic              ack_o,
  output logic              err_o,
  output logic [WORD-1:0]   dat_o,
  output logic [WORD-1:0]   adr_o,
  output logic [SLAVES-1:0] slvStb_o,
  output logic [SLAVES-1:0] slvCyc_o,
  output logic              busy_o
);
  localparam int SEL_L  = SEL_H - SEL_W + 1;
  localparam int ADDR_H = SEL_L - 1;
  localparam logic [SEL_W:0] NSLV = (SEL_W + 1)'(SLAVES);

  if (TIMEOUT < 1 || SLAVES < 1 || SLAVES > (1 << SEL_W)) begin : g_param_chk
    $error("wb_slave_decoder: illegal TIMEOUT/SLAVES/SEL_W combination");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel, sel_q;
  logic             sel_ok, active, timeout_hit;

  assign sel    = adr_i[SEL_H:SEL_L];
  assign sel_ok = ({1'b0, sel} < NSLV);
  assign active = (state == ACTIVE);
  assign busy_o = (state != IDLE);
  assign adr_o  = WORD'(adr_i[ADDR_H:0]);

  // Routing only ever follows the latched select, never the live address.
  always_comb begin
    slvStb_o = '0;
    slvCyc_o = '0;
    if (active) begin
      slvStb_o[sel_q] = stb_i;
      slvCyc_o[sel_q] = cyc_i;
    end
  end

  assign ack_o = active & stb_i & slvAck_i[sel_q];
  assign dat_o = slvDat_i[active ? sel_q : '0];

`ifdef WB_DEC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // Counts consecutive un-acked strobe cycles; any gap in stb_i restarts the watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i || !active || !stb_i || ack_o) wait_cnt <= '0;
    else                                     wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = active && !ack_o && (wait_cnt == CNT_W'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      sel_q <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: if (cyc_i && stb_i) begin
          if (sel_ok) begin
            sel_q <= sel;
            state <= ACTIVE;
          end else begin
            state <= ERROR;
            err_o <= 1'b1;
          end
        end
        // Dropping cyc_i wins over a simultaneous watchdog expiry.
        ACTIVE: if (!cyc_i) state <= IDLE;
          else if (timeout_hit) begin
            state <= ERROR;
            err_o <= 1'b1;
          end
        ERROR: if (!cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_slave_decoder.sv
// Bench for wb_slave_decoder: a 4-slave and a 3-slave instance share one master;
// expectations come from per-transaction arithmetic on select, ack latency and TIMEOUT.
module tb_wb_slave_decoder;
  localparam int TO = 15;
`ifdef WB_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cyc, stb;
  logic [15:0] adr;
  logic [3:0]  sack4;
  logic [15:0] sdat4 [4];
  logic [2:0]  sack3;
  logic [15:0] sdat3 [3];

  logic        m_ack4, m_err4, m_busy4, m_ack3, m_err3, m_busy3;
  logic [15:0] m_dat4, m_adr4, m_dat3, m_adr3;
  logic [3:0]  stb_o4, cyc_o4;
  logic [2:0]  stb_o3, cyc_o3;

  int total = 0;
  int bad   = 0;
  int ntx   = 0;

  always #5 clk = ~clk;

  wb_slave_decoder #(.WORD(16), .SLAVES(4), .TIMEOUT(TO)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
    .slvAck_i(sack4), .slvDat_i(sdat4),
    .ack_o(m_ack4), .err_o(m_err4), .dat_o(m_dat4), .adr_o(m_adr4),
    .slvStb_o(stb_o4), .slvCyc_o(cyc_o4), .busy_o(m_busy4)
  );

  wb_slave_decoder #(.WORD(16), .SLAVES(3), .TIMEOUT(TO)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
    .slvAck_i(sack3), .slvDat_i(sdat3),
    .ack_o(m_ack3), .err_o(m_err3), .dat_o(m_dat3), .adr_o(m_adr3),
    .slvStb_o(stb_o3), .slvCyc_o(cyc_o3), .busy_o(m_busy3)
  );

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic chk4(input string t, input logic [3:0] s, input logic [3:0] c,
                      input logic a, input logic e, input logic b);
    chk({t, " stb4"},  32'(stb_o4),  32'(s));
    chk({t, " cyc4"},  32'(cyc_o4),  32'(c));
    chk({t, " ack4"},  32'(m_ack4),  32'(a));
    chk({t, " err4"},  32'(m_err4),  32'(e));
    chk({t, " busy4"}, 32'(m_busy4), 32'(b));
  endtask

  task automatic chk3(input string t, input logic [2:0] s, input logic [2:0] c,
                      input logic a, input logic e, input logic b);
    chk({t, " stb3"},  32'(stb_o3),  32'(s));
    chk({t, " cyc3"},  32'(cyc_o3),  32'(c));
    chk({t, " ack3"},  32'(m_ack3),  32'(a));
    chk({t, " err3"},  32'(m_err3),  32'(e));
    chk({t, " busy3"}, 32'(m_busy3), 32'(b));
  endtask

  task automatic clear_slaves();
    sack4 = '0;
    sack3 = '0;
    for (int i = 0; i < 4; i++) begin
      sdat4[i] = 16'($urandom);
      if (i < 3) sdat3[i] = sdat4[i];
    end
  endtask

  task automatic set_ack(input int s, input logic [15:0] d);
    sack4[s] = 1'b1;
    sdat4[s] = d;
    if (s < 3) begin
      sack3[s] = 1'b1;
      sdat3[s] = d;
    end
  endtask

  // One single-beat bus cycle; the addressed slave acks lat cycles after first seeing its strobe.
  task automatic run_txn(input logic [15:0] a, input int lat, input logic [15:0] d);
    int sel, end_k;
    bit tmo, map3, hit, err_k;
    logic [3:0] s4;
    string t;
    sel   = int'(a[15:14]);
    map3  = (sel < 3);
    tmo   = TO_EN && (lat > TO);
    end_k = tmo ? TO + 3 : lat + 1;
    ntx++;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a; clear_slaves();
    #1;
    t = $sformatf("tx%0d k0", ntx);
    chk({t, " adr4"}, 32'(m_adr4), 32'(a & 16'h3fff));
    chk({t, " adr3"}, 32'(m_adr3), 32'(a & 16'h3fff));
    chk4(t, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    chk3(t, 3'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      clear_slaves();
      hit = !tmo && (k == lat + 1);
      if (hit) set_ack(sel, d);
      #1;
      t     = $sformatf("tx%0d k%0d", ntx, k);
      s4    = (!tmo || k <= TO + 1) ? 4'(1 << sel) : 4'b0;
      err_k = tmo && (k == TO + 2);
      chk4(t, s4, s4, hit, err_k, 1'b1);
      if (hit) chk({t, " dat4"}, 32'(m_dat4), 32'(d));
      if (map3) begin
        chk3(t, s4[2:0], s4[2:0], hit, err_k, 1'b1);
        if (hit) chk({t, " dat3"}, 32'(m_dat3), 32'(d));
      end else begin
        chk3(t, 3'b0, 3'b0, 1'b0, k == 1, 1'b1);
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; clear_slaves();
    #1;
    t = $sformatf("tx%0d drop", ntx);
    chk4(t, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    chk3(t, 3'b0, 3'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    t = $sformatf("tx%0d idle", ntx);
    chk4(t, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    chk3(t, 3'b0, 3'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] ra;
    logic [1:0]  rs;
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; adr = 16'h8012;
    clear_slaves();
    sack4 = '1; sack3 = '1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk4("reset", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    chk3("reset", 3'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; clear_slaves();
    @(negedge clk);
    #1;
    chk4("post-reset", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

    // Read slave 2, one cycle of slave wait.
    run_txn(16'h8012, 1, 16'hBEEF);
    // Unmapped on the 3-slave instance, mapped slave 3 on the 4-slave one.
    run_txn(16'hC000, 2, 16'h5A5A);
    // Slave 1 never acks within the watchdog window.
    run_txn(16'h4321, 100, 16'h1111);
    // Ack lands exactly on the timeout cycle.
    run_txn(16'h4007, TO, 16'h2222);
    run_txn(16'h0000, 0, 16'h3333);

    // Block transfer: second strobe with a different upper address stays on slave 2.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 16'h8012; clear_slaves();
    #1;
    chk4("blk k0", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk4("blk k1", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_ack(2, 16'hBEEF);
    #1;
    chk4("blk ack1", 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1);
    chk("blk dat1", 32'(m_dat4), 32'h0000BEEF);
    chk("blk adr1", 32'(m_adr4), 32'h00000012);
    @(negedge clk);
    clear_slaves(); stb = 1'b0; adr = 16'h0004;
    #1;
    chk4("blk gap", 4'b0, 4'b0100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    stb = 1'b1;
    #1;
    chk4("blk stb2", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    chk("blk adr2", 32'(m_adr4), 32'h00000004);
    @(negedge clk);
    set_ack(2, 16'h1234);
    #1;
    chk4("blk ack2", 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1);
    chk("blk dat2", 32'(m_dat4), 32'h00001234);
    @(negedge clk);
    clear_slaves(); cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    #1;
    chk4("blk idle", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a cycle aborts with no ack or error.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 16'h4000; clear_slaves();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sack4[1] = 1'b1; sack3[1] = 1'b1;
    #1;
    chk4("midrst", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    chk3("midrst", 3'b0, 3'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; clear_slaves();
    @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rs = 2'($urandom_range(0, 3));
      ra[15:14] = rs;
      run_txn(ra, $urandom_range(0, 20), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_slave_decoder.md
Name: wb_slave_decoder

Overview:
- Parametrised Wishbone slave-side address decoder/router, the next generation of the bus slave arbiter.
- Sits between the single CPU bus master and N slaves (memory, I/O).
- Registers the slave selection at the start of each bus cycle and holds it for the whole cycle (cyc_i high).
- Adds bus-error signalling for unmapped selects and for slaves that never ack (watchdog timeout).

Parameters:
- WORD, 16, data/address width.
- SLAVES, 4, number of slave ports (1..2^SEL_W; need not be a power of two).
- SEL_W, $clog2(SLAVES) (minimum 1), width of the slave-select field.
- SEL_H, WORD-1, MSB of the select field in adr_i; SEL_L = SEL_H-SEL_W+1; ADDR_H = SEL_L-1.
- TIMEOUT, 15, max wait cycles for a slave ack before error (>=1).

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cyc_i  in  1  master bus cycle.
- stb_i  in  1  master strobe.
- adr_i  in  WORD  master address.
- slvAck_i  in  SLAVES  per-slave ack.
- slvDat_i  in  WORD x SLAVES  per-slave read data (unpacked array).
- ack_o  out  1  ack to master.
- err_o  out  1  bus error to master (one-cycle pulse).
- dat_o  out  WORD  read data to master.
- adr_o  out  WORD  local address to slaves: adr_i[ADDR_H:0], upper bits zero.
- slvStb_o  out  SLAVES  one-hot strobe to slaves.
- slvCyc_o  out  SLAVES  one-hot cycle to slaves.
- busy_o  out  1  high in ACTIVE or ERROR.

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, sel_q=0, wait_cnt=0, err_o=0. Combinational outputs then follow: ack_o=0, slvStb_o=0, slvCyc_o=0, busy_o=0. Reset mid-cycle aborts with no ack/err.
- sel = adr_i[SEL_H:SEL_L], decoded every cycle; adr_o and dat_o are combinational.
- IDLE:
  - slvStb_o=slvCyc_o=0, ack_o=0.
  - On cyc_i&stb_i: if sel<SLAVES, latch sel_q=sel, wait_cnt=0, go ACTIVE; else go ERROR with err_o=1 next cycle.
  - Decode latency: 1 cycle; slave sees its strobe the cycle after the master raises stb_i.
- ACTIVE:
  - slvCyc_o[sel_q]=cyc_i and slvStb_o[sel_q]=stb_i; all other bits 0.
  - ack_o = slvAck_i[sel_q]&stb_i; dat_o = slvDat_i[sel_q].
  - Selection is locked for the whole cyc_i period; further strobes within the same cyc_i go to sel_q regardless of adr_i upper bits (block transfers).
  - wait_cnt increments each cycle with stb_i&~ack; it clears on ack or when stb_i is low.
  - When wait_cnt==TIMEOUT and no ack that cycle: go ERROR, err_o=1 next cycle, slave strobe/cycle dropped.
  - cyc_i low: go IDLE (takes precedence over timeout).
- ERROR:
  - err_o high for exactly the first cycle in ERROR, then 0. slvStb_o/slvCyc_o=0, ack_o=0.
  - Stay in ERROR until cyc_i low, then go IDLE.
- ack_o and err_o are never high together; a same-cycle ack beats timeout.
- dat_o is defined only while ack_o is high; it reads slvDat_i[0] in IDLE/ERROR.

Optional Feature:
- Macro: WB_DEC_TIMEOUT_EN.
- Defined: watchdog counter and timeout-to-ERROR path as above.
- Undefined: no wait_cnt logic; ACTIVE waits indefinitely for ack; unmapped-select errors still generated; TIMEOUT parameter ignored.

Test Plan:
- Reset: rst_i=1 for 2 cycles with cyc_i=stb_i=1 -> ack_o=0, err_o=0, slvStb_o=0, busy_o=0.
- Read slave 2: adr_i=16'h8012, cyc/stb high, slave 2 acks 1 cycle after its strobe with data 16'hBEEF -> slvStb_o=4'b0100 one cycle after stb_i, adr_o=16'h0012, ack_o=1 with dat_o=16'hBEEF.
- Block lock: within one cyc_i, second strobe with adr_i=16'h0004 -> slvStb_o stays 4'b0100, no IDLE pass.
- Unmapped: SLAVES=3, adr_i=16'hC000 -> no slave strobe, err_o=1 for exactly one cycle; busy_o held until cyc_i drops.
- Timeout (macro on, TIMEOUT=15): slave 1 never acks -> err_o pulses 16 cycles after the slave strobe first asserts, slvStb_o=0 afterwards. With the macro off, no err_o after 100 cycles.
- Ack on the timeout cycle -> ack_o=1, err_o stays 0, state ACTIVE.
